spec_fifo_ctrl: RTL and testbench
=================================

# spec_fifo_ctrl

Controller for the speculative receive FIFO behind the UART receiver. It accepts the receiver's speculative write, commit and rollback strobes, and manages speculative, committed and read pointers over a small dual-port memory. The consumer only sees frames whose stop bit has validated. It sits between the UART RX datapath (CLK288MHZ domain) and the downstream byte consumer.

## Interface
- DEPTH_LOG2, 4: log2 of FIFO entries (16).
- DATA_W, 9: entry width; bit 8 is the parity-error flag, bits 7:0 are the byte.

- CLK288MHZ, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- wr_data, input, DATA_W: frame from the receiver; sampled when write_en=1.
- write_en, input, 1: one-cycle speculative write strobe.
- commit_write, input, 1: one-cycle strobe that commits the pending entry.
- rollback_write, input, 1: one-cycle strobe that discards the pending entry.
- rd_ready, input, 1: consumer accepts rd_data.
- rd_valid, output, 1: a committed entry is available.
- rd_data, output, DATA_W: head entry; forced to 0 when rd_valid=0.
- count, output, DEPTH_LOG2+1: number of committed, unread entries.
- full, output, 1: no free slot for a speculative write.
- overflow, output, 1: sticky; set when a write is dropped.
- ovf_clr, input, 1: clears overflow (and stats counters when compiled in).

## Operation
- Pointers wr_ptr, commit_ptr and rd_ptr are each DEPTH_LOG2+1 bits, with the MSB used as a wrap bit. Memory index is ptr[DEPTH_LOG2-1:0].
- full = (wr_ptr − rd_ptr) == 2^DEPTH_LOG2.
- count = commit_ptr − rd_ptr.
- rd_valid = (commit_ptr != rd_ptr).
- Invariant: rd_ptr ≤ commit_ptr ≤ wr_ptr (modulo the wrap bit).
- FSM states:
  - IDLE: no pending entry.
    - write_en with !full: write mem[wr_ptr], wr_ptr+1, go to SPEC.
    - write_en with full: set overflow, go to DROP.
    - commit_write and rollback_write are ignored.
  - SPEC: one entry pending.
    - commit_write: commit_ptr←wr_ptr, go to IDLE.
    - rollback_write: wr_ptr←commit_ptr, go to IDLE.
    - write_en (protocol slip): implicit commit of the pending entry, then handle the new write as in IDLE, in the same cycle.
  - DROP: the pending frame was dropped.
    - commit_write or rollback_write: go to IDLE with no pointer change.
    - write_en: handled as in IDLE.
- Simultaneous commit_write and rollback_write: rollback wins.
- Read: when rd_valid & rd_ready, rd_ptr+1 at the edge. rd_ready with rd_valid=0 is ignored.
- A read in the same cycle as write_en does not free a slot for that write. full is evaluated on pre-edge pointers.
- Reset (asynchronous, any time, including mid-frame):
  - All pointers go to 0 and state goes to IDLE.
  - Outputs: rd_valid=0, rd_data=0, count=0, full=0, overflow=0.
  - Memory contents are not cleared.
- ovf_clr together with a drop in the same cycle: overflow remains set.

## Timing
- write_en at cycle N: memory and wr_ptr update at edge N.
- commit_write at cycle M (earliest M=N+1): commit_ptr updates at edge M.
  - rd_valid is high in cycle M+1.
  - rd_data is valid in that same cycle, because the memory read is asynchronous.
- Read latency is zero: rd_data reflects the head entry combinationally from registered rd_ptr.
- Back-to-back reads sustain one entry per cycle.
- full and count are combinational from registered pointers, so they change the cycle after the causing edge.

## Configuration
- SPEC_FIFO_STATS_EN defined:
  - Adds output ports rollback_cnt[15:0] and drop_cnt[15:0].
  - Both are saturating counters that increment on each rollback taken in SPEC and each drop entering DROP.
  - Both reset to 0 and are cleared by ovf_clr.
- SPEC_FIFO_STATS_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum: IDLE, SPEC, DROP (2 bits);
  - the UART_DATA_W=9 constant;
  - the PARITY_BIT=8 constant.
- Sub-module spec_fifo_mem: dual-port memory with synchronous write and asynchronous read, parameterised by DATA_W and DEPTH_LOG2.
- spec_fifo_ctrl holds the pointers, FSM and flags.

## Test plan
- Write 0x041 then commit on the next cycle → rd_valid=1 in the cycle after commit, rd_data=0x041, count=1. A read with rd_ready → count=0, rd_valid=0.
- Write 0x155 then rollback; write 0x0AA then commit → the only entry read is 0x0AA and the 0x155 slot is reused.
- 16 committed writes with no reads → full=1. A 17th write_en sets overflow, and its commit leaves count=16. ovf_clr → overflow=0.
- Commit and rollback asserted in the same cycle after writing 0x012 → rollback wins, count=0, rd_valid=0.
- 40 write/commit/read cycles with rd_ready toggling → data order preserved across pointer wrap, with no loss or duplication.
- Assert reset mid-SPEC after writing 0x033 → all outputs are 0 immediately (asynchronous). After reset release, a commit_write is ignored and count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path types and constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, SPEC, DROP} state_t;
  localparam int UART_DATA_W = 9;
  localparam int PARITY_BIT  = 8;
endpackage

// File: rtl/spec_fifo_mem.sv
// spec_fifo_mem: dual-port storage, synchronous write and asynchronous read.
module spec_fifo_mem #(
  parameter int DATA_W     = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/spec_fifo_ctrl.sv
// spec_fifo_ctrl: speculative RX FIFO; only committed frames reach the consumer.
// Optional SPEC_FIFO_STATS_EN adds saturating rollback/drop counters.
module spec_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic              CLK288MHZ,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              write_en,
  input  logic              commit_write,
  input  logic              rollback_write,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [DEPTH_LOG2:0] count,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef SPEC_FIFO_STATS_EN
  ,
  output logic [15:0]       rollback_cnt,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << DEPTH_LOG2);
  state_t r_state, w_nxt_state;
  logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, w_nxt_wr, w_nxt_cm;
  logic w_mem_we, w_drop, w_rb, w_rd_fire;
  logic [DATA_W-1:0] w_mem_q;
  logic r_ovf;
  assign full      = (r_wr_ptr - r_rd_ptr) == DEPTH;
  assign count     = r_cm_ptr - r_rd_ptr;
  assign rd_valid  = r_cm_ptr != r_rd_ptr;
  assign rd_data   = rd_valid ? w_mem_q : '0;
  assign overflow  = r_ovf;
  assign w_rd_fire = rd_valid & rd_ready;
  // A write arriving in SPEC implicitly commits the pending entry first.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wr    = r_wr_ptr;
    w_nxt_cm    = r_cm_ptr;
    w_mem_we    = 1'b0;
    w_drop      = 1'b0;
    w_rb        = 1'b0;
    if (write_en) begin
      if (r_state == SPEC) w_nxt_cm = r_wr_ptr;
      if (full) begin
        w_drop      = 1'b1;
        w_nxt_state = DROP;
      end else begin
        w_mem_we    = 1'b1;
        w_nxt_wr    = r_wr_ptr + 1'b1;
        w_nxt_state = SPEC;
      end
    end else if (r_state == SPEC && rollback_write) begin
      w_rb        = 1'b1;
      w_nxt_state = IDLE;
    end else if (r_state == SPEC && commit_write) begin
      w_nxt_cm    = r_wr_ptr;
      w_nxt_state = IDLE;
    end else if (r_state == DROP && (commit_write || rollback_write)) begin
      w_nxt_state = IDLE;
    end
  end
  always_ff @(posedge CLK288MHZ or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_wr_ptr <= w_rb ? r_cm_ptr : w_nxt_wr;
      r_cm_ptr <= w_nxt_cm;
      r_rd_ptr <= w_rd_fire ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_ovf    <= w_drop ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
    end
  spec_fifo_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_clk   (CLK288MHZ),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_mem_q)
  );
`ifdef SPEC_FIFO_STATS_EN
  logic [15:0] r_rb_cnt, r_drop_cnt;
  always_ff @(posedge CLK288MHZ or negedge reset)
    if (!reset) begin
      r_rb_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_rb_cnt   <= ovf_clr ? '0 : (w_rb && r_rb_cnt != '1) ? r_rb_cnt + 1'b1 : r_rb_cnt;
      r_drop_cnt <= ovf_clr ? '0 : (w_drop && r_drop_cnt != '1) ? r_drop_cnt + 1'b1 : r_drop_cnt;
    end
  assign rollback_cnt = r_rb_cnt;
  assign drop_cnt     = r_drop_cnt;
`endif
endmodule

// File: tb/tb_spec_fifo_ctrl.sv
// tb_spec_fifo_ctrl: directed and randomized checks against a queue-based model.
module tb_spec_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] wr_data;
  logic       write_en, commit_write, rollback_write, rd_ready, ovf_clr;
  logic       rd_valid, full, overflow;
  logic [8:0] rd_data;
  logic [4:0] count;
`ifdef SPEC_FIFO_STATS_EN
  logic [15:0] rollback_cnt, drop_cnt;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [8:0] m_q[$];
  logic [8:0] m_pd;
  bit   m_pend, m_ovf;
  int   m_mode, m_rbc, m_drc;
  always #5 clk = ~clk;
  spec_fifo_ctrl dut (
    .CLK288MHZ      (clk),
    .reset          (reset),
    .wr_data        (wr_data),
    .write_en       (write_en),
    .commit_write   (commit_write),
    .rollback_write (rollback_write),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr)
`ifdef SPEC_FIFO_STATS_EN
    ,
    .rollback_cnt   (rollback_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_pend = 0;
    m_ovf  = 0;
    m_mode = 0;
    m_rbc  = 0;
    m_drc  = 0;
  endtask
  // Model: committed queue plus at most one pending entry; mode 0 idle, 1 pending, 2 dropped.
  task automatic model_step(input bit we, input logic [8:0] d, input bit cm, input bit rb,
                            input bit rdy, input bit clr);
    bit was_full, dropped;
    was_full = (m_q.size() + int'(m_pend)) == 16;
    dropped  = 0;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (we) begin
      if (m_mode == 1) m_q.push_back(m_pd);
      m_pend = 0;
      if (!was_full) begin
        m_pend = 1;
        m_pd   = d;
        m_mode = 1;
      end else begin
        m_mode  = 2;
        m_ovf   = 1;
        dropped = 1;
        if (m_drc < 65535) m_drc++;
      end
    end else if (m_mode == 1 && rb) begin
      m_pend = 0;
      m_mode = 0;
      if (m_rbc < 65535) m_rbc++;
    end else if (m_mode == 1 && cm) begin
      m_q.push_back(m_pd);
      m_pend = 0;
      m_mode = 0;
    end else if (m_mode == 2 && (cm || rb)) m_mode = 0;
    if (clr) begin
      if (!dropped) m_ovf = 0;
      m_rbc = 0;
      m_drc = 0;
    end
  endtask
  task automatic compare_all();
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
    check("rd_data",  32'(rd_data),  m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
    check("count",    32'(count),    32'(m_q.size()));
    check("full",     32'(full),     32'((m_q.size() + int'(m_pend)) == 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SPEC_FIFO_STATS_EN
    check("rollback_cnt", 32'(rollback_cnt), 32'(m_rbc));
    check("drop_cnt",     32'(drop_cnt),     32'(m_drc));
`endif
  endtask
  task automatic step(input bit we, input logic [8:0] d, input bit cm, input bit rb,
                      input bit rdy, input bit clr);
    write_en = we; wr_data = d; commit_write = cm; rollback_write = rb;
    rd_ready = rdy; ovf_clr = clr;
    model_step(we, d, cm, rb, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 9'h0, 0, 0, 0, 0);
  endtask
  initial begin
    bit rdy_t;
    reset = 1'b0;
    write_en = 0; wr_data = '0; commit_write = 0; rollback_write = 0; rd_ready = 0; ovf_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;
    // Write, commit next cycle, then read.
    step(1, 9'h041, 0, 0, 0, 0);
    step(0, 9'h0, 1, 0, 0, 0);
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", 32'(rd_data), 32'h041);
    check("t1_count", 32'(count), 32'd1);
    step(0, 9'h0, 0, 0, 1, 0);
    check("t1_drained", 32'(count), 32'd0);
    // Rollback reuses the slot.
    step(1, 9'h155, 0, 0, 0, 0);
    step(0, 9'h0, 0, 1, 0, 0);
    check("t2_rb_count", 32'(count), 32'd0);
    step(1, 9'h0AA, 0, 0, 0, 0);
    step(0, 9'h0, 1, 0, 0, 0);
    check("t2_data", 32'(rd_data), 32'h0AA);
    check("t2_count", 32'(count), 32'd1);
    step(0, 9'h0, 0, 0, 1, 0);
    // Fill to full, then overflow on the 17th write.
    for (int i = 0; i < 16; i++) begin
      step(1, 9'(i + 9'h100), 0, 0, 0, 0);
      step(0, 9'h0, 1, 0, 0, 0);
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_count16", 32'(count), 32'd16);
    step(1, 9'h1FF, 0, 0, 0, 0);
    step(0, 9'h0, 1, 0, 0, 0);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count_after", 32'(count), 32'd16);
    step(0, 9'h0, 0, 0, 0, 1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(0, 9'h0, 0, 0, 1, 0);
    check("t3_empty", 32'(count), 32'd0);
    // Commit with rollback in the same cycle.
    step(1, 9'h012, 0, 0, 0, 0);
    step(0, 9'h0, 1, 1, 0, 0);
    check("t4_count", 32'(count), 32'd0);
    check("t4_valid", 32'(rd_valid), 32'd0);
    // Write/commit/read with toggling rd_ready across pointer wrap.
    rdy_t = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 9'($urandom), 0, 0, rdy_t, 0);
      rdy_t = ~rdy_t;
      step(0, 9'h0, 1, 0, rdy_t, 0);
    end
    for (int i = 0; i < 24; i++) step(0, 9'h0, 0, 0, 1, 0);
    check("t5_drained", 32'(count), 32'd0);
    // Randomized protocol traffic including drops and slips.
    for (int i = 0; i < 400; i++) begin
      bit we, cm, rb;
      we = ($urandom % 3) == 0;
      cm = !we && ($urandom % 2);
      rb = !we && (($urandom % 4) == 0);
      step(we, 9'($urandom), cm, rb, ($urandom % 3) == 0, ($urandom % 16) == 0);
    end
    // Asynchronous reset mid-SPEC.
    step(1, 9'h033, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_valid", 32'(rd_valid), 32'd0);
    check("t6_data", 32'(rd_data), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 9'h0, 1, 0, 0, 0);
    idle(1);
    check("t6_commit_ignored", 32'(count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
